// File: rtl/tictactoe_board_ctrl.sv
// TicTacToe game-state controller: move handshake, board, sequential win/draw check, VGA render.
// Optional green win-line highlight when WIN_HILITE_EN is defined.
module tictactoe_board_ctrl #(
  parameter int unsigned BOARD_X0 = 80,
  parameter int unsigned CELL     = 160,
  parameter int unsigned LINE_W   = 4
) (
  input  logic       CLK25,
  input  logic       RST_BTN,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_err,
  output logic       turn,
  output logic [1:0] status,
  input  logic       vsync,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned NCELL = 9;
  localparam int unsigned BW    = 2 * NCELL;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_XWIN = 2'b01;
  localparam logic [1:0] ST_OWIN = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;
  localparam logic [1:0] MARK_X  = 2'b01;
  localparam logic [1:0] MARK_O  = 2'b10;

  localparam logic [7:0] MARK_LO = 8'd20;
  localparam logic [7:0] MARK_HI = 8'd140;
  localparam logic [7:0] O_IN_LO = 8'd26;
  localparam logic [7:0] O_IN_HI = 8'd134;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_FINAL} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cell_q, cell_d;
  logic [2:0]      line_q, line_d;
  logic [BW-1:0]   pend_q, pend_d;
  logic [BW-1:0]   disp_q, disp_d;
  logic [1:0]      status_q, status_d;
  logic            turn_q, turn_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            vs_prev_q;
  logic [23:0]     rgb_q, rgb_d;
`ifdef WIN_HILITE_EN
  logic [NCELL-1:0] win_q, win_d;
  logic [NCELL-1:0] disp_win_q, disp_win_d;
`endif

  logic [NCELL-1:0] line_cells;
  logic [1:0]       mark;
  logic             occupied, hit, full;

  // Cells (row-major bit index) covered by each of the 8 lines, in check order.
  function automatic logic [NCELL-1:0] line_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return 9'b000_000_111;
      3'd1:    return 9'b000_111_000;
      3'd2:    return 9'b111_000_000;
      3'd3:    return 9'b001_001_001;
      3'd4:    return 9'b010_010_010;
      3'd5:    return 9'b100_100_100;
      3'd6:    return 9'b100_010_001;
      default: return 9'b001_010_100;
    endcase
  endfunction

  // Game FSM next-state and outputs.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    line_d     = line_q;
    pend_d     = pend_q;
    status_d   = status_q;
    turn_d     = turn_q;
    err_d      = 1'b0;
`ifdef WIN_HILITE_EN
    win_d      = win_q;
`endif
    line_cells = line_mask(line_q);
    mark       = turn_q ? MARK_O : MARK_X;
    occupied   = 1'b0;
    hit        = 1'b1;
    full       = 1'b1;
    for (int i = 0; i < NCELL; i++) begin
      if (cell_q == 4'(i) && pend_q[2*i +: 2] != 2'b00) occupied = 1'b1;
      if (line_cells[i] && pend_q[2*i +: 2] != mark) hit = 1'b0;
      if (pend_q[2*i +: 2] == 2'b00) full = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (move_valid && ready_q) begin
          state_d = S_APPLY;
          cell_d  = move_cell;
        end
      end
      S_APPLY: begin
        if (cell_q > 4'd8 || occupied) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < NCELL; i++) begin
            if (cell_q == 4'(i)) pend_d[2*i +: 2] = mark;
          end
          line_d  = 3'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          status_d = turn_q ? ST_OWIN : ST_XWIN;
`ifdef WIN_HILITE_EN
          win_d    = line_cells;
`endif
          state_d  = S_IDLE;
        end else if (line_q == 3'd7) begin
          state_d = S_FINAL;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
      S_FINAL: begin
        if (full) status_d = ST_DRAW;
        else      turn_d   = ~turn_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart overrides everything, including an in-flight check or a same-cycle handshake.
    if (new_game) begin
      state_d  = S_IDLE;
      pend_d   = '0;
      status_d = ST_PLAY;
      turn_d   = 1'b0;
      err_d    = 1'b0;
`ifdef WIN_HILITE_EN
      win_d    = '0;
`endif
    end

    ready_d = (state_d == S_IDLE) && (status_d == ST_PLAY);
  end

  // Display copy refreshes only on a vsync falling edge so a frame never tears.
  always_comb begin
    disp_d = disp_q;
`ifdef WIN_HILITE_EN
    disp_win_d = disp_win_q;
`endif
    if (vs_prev_q && !vsync) begin
      disp_d = pend_q;
`ifdef WIN_HILITE_EN
      disp_win_d = win_q;
`endif
    end
  end

  logic       in_x, in_y, grid, in_mark, x_hit, o_hit, cwin;
  logic [9:0] xo;
  logic [1:0] col, row, cmark;
  logic [7:0] lx, ly, dxy;
  logic [8:0] sxy;
  logic [3:0] cidx;

  // Pixel renderer: coordinate decode by comparison, then grid/mark/background priority.
  always_comb begin
    in_x = (x >= 10'(BOARD_X0)) && (x < 10'(BOARD_X0 + 3 * CELL));
    in_y = y < 9'(3 * CELL);
    xo   = x - 10'(BOARD_X0);
    if (xo < 10'(CELL)) begin
      col = 2'd0; lx = 8'(xo);
    end else if (xo < 10'(2 * CELL)) begin
      col = 2'd1; lx = 8'(xo - 10'(CELL));
    end else begin
      col = 2'd2; lx = 8'(xo - 10'(2 * CELL));
    end
    if (y < 9'(CELL)) begin
      row = 2'd0; ly = 8'(y);
    end else if (y < 9'(2 * CELL)) begin
      row = 2'd1; ly = 8'(y - 9'(CELL));
    end else begin
      row = 2'd2; ly = 8'(y - 9'(2 * CELL));
    end
    cidx  = 4'(row) * 4'd3 + 4'(col);
    cmark = 2'b00;
    cwin  = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      if (cidx == 4'(i)) begin
        cmark = disp_q[2*i +: 2];
`ifdef WIN_HILITE_EN
        cwin  = disp_win_q[i];
`endif
      end
    end
    grid    = (col != 2'd0 && lx < 8'(LINE_W)) || (row != 2'd0 && ly < 8'(LINE_W));
    in_mark = lx >= MARK_LO && lx < MARK_HI && ly >= MARK_LO && ly < MARK_HI;
    dxy     = (lx >= ly) ? lx - ly : ly - lx;
    sxy     = {1'b0, lx} + {1'b0, ly};
    // Anti-diagonal: |lx + ly - 159| < 4, i.e. 156..162.
    x_hit   = in_mark && (dxy < 8'd4 || (sxy > 9'd155 && sxy < 9'd163));
    o_hit   = in_mark && (lx < O_IN_LO || lx >= O_IN_HI || ly < O_IN_LO || ly >= O_IN_HI);

    rgb_d = 24'h00_00_00;
    if (video_on && in_x && in_y) begin
      if (grid)                           rgb_d = 24'hFF_FF_FF;
      else if (cmark == MARK_X && x_hit)  rgb_d = 24'hFF_00_00;
      else if (cmark == MARK_O && o_hit)  rgb_d = 24'h00_00_FF;
      else if (cwin)                      rgb_d = 24'h00_40_00;
    end
  end

  always_ff @(posedge CLK25 or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q    <= S_IDLE;
      cell_q     <= 4'd0;
      line_q     <= 3'd0;
      pend_q     <= '0;
      disp_q     <= '0;
      status_q   <= ST_PLAY;
      turn_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      vs_prev_q  <= 1'b1;
      rgb_q      <= 24'h00_00_00;
`ifdef WIN_HILITE_EN
      win_q      <= '0;
      disp_win_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      line_q     <= line_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      status_q   <= status_d;
      turn_q     <= turn_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      vs_prev_q  <= vsync;
      rgb_q      <= rgb_d;
`ifdef WIN_HILITE_EN
      win_q      <= win_d;
      disp_win_q <= disp_win_d;
`endif
    end
  end

  assign move_ready = ready_q;
  assign move_err   = err_q;
  assign turn       = turn_q;
  assign status     = status_q;
  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Self-checking bench for tictactoe_board_ctrl: directed game scenarios plus random games
// compared against an array-based game/render model.
module tb_tictactoe_board_ctrl;

  logic       CLK25 = 1'b0;
  logic       RST_BTN;
  logic       new_game, move_valid, vsync, video_on;
  logic [3:0] move_cell;
  logic [9:0] x;
  logic [8:0] y;
  logic       move_ready, move_err, turn;
  logic [1:0] status;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  tictactoe_board_ctrl dut (
    .CLK25(CLK25), .RST_BTN(RST_BTN), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .move_ready(move_ready), .move_err(move_err), .turn(turn),
    .status(status), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #20 CLK25 = ~CLK25;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err_exp = 0;
  int n_err_seen = 0;

  int board [9];
  int disp  [9];
  bit win   [9];
  bit disp_win [9];
  int m_turn, m_status;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always @(posedge CLK25) if (move_err === 1'b1) n_err_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin board[i] = 0; win[i] = 0; end
    m_turn = 0; m_status = 0;
  endtask

  task automatic model_move(input int c, output bit legal);
    int mk;
    legal = (c <= 8);
    if (legal) legal = (board[c] == 0);
    if (!legal) begin n_err_exp++; return; end
    mk = m_turn ? 2 : 1;
    board[c] = mk;
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] == mk && board[lines[l][1]] == mk && board[lines[l][2]] == mk) begin
        m_status = mk;
        for (int j = 0; j < 3; j++) win[lines[l][j]] = 1;
        return;
      end
    end
    for (int i = 0; i < 9; i++) if (board[i] == 0) begin m_turn ^= 1; return; end
    m_status = 3;
  endtask

  function automatic logic [23:0] exp_rgb(input int px, input int py, input bit von);
    int xo, col, row, lx, ly, m, d, s;
    if (!von) return 24'h0;
    if (px < 80 || px >= 560 || py >= 480) return 24'h0;
    xo = px - 80;
    col = xo / 160; lx = xo % 160;
    row = py / 160; ly = py % 160;
    if ((col > 0 && lx < 4) || (row > 0 && ly < 4)) return 24'hFFFFFF;
    m = disp[row * 3 + col];
    if (lx >= 20 && lx < 140 && ly >= 20 && ly < 140) begin
      d = lx - ly; if (d < 0) d = -d;
      s = lx + ly - 159; if (s < 0) s = -s;
      if (m == 1 && (d < 4 || s < 4)) return 24'hFF0000;
      if (m == 2 && (lx < 26 || lx >= 134 || ly < 26 || ly >= 134)) return 24'h0000FF;
    end
`ifdef WIN_HILITE_EN
    if (disp_win[row * 3 + col]) return 24'h004000;
`endif
    return 24'h0;
  endfunction

  task automatic check_pix(input string tag, input int px, input int py, input bit von);
    x = 10'(px); y = 9'(py); video_on = von;
    @(negedge CLK25);
    check_eq(tag, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb(px, py, von)});
  endtask

  task automatic do_vsync();
    vsync = 1'b0;
    @(negedge CLK25);
    vsync = 1'b1;
    for (int i = 0; i < 9; i++) begin disp[i] = board[i]; disp_win[i] = win[i]; end
    @(negedge CLK25);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_status"}, 32'(status), 32'(m_status));
    check_eq({tag, "_turn"}, 32'(turn), 32'(m_turn));
    check_eq({tag, "_ready"}, 32'(move_ready), 32'(m_status == 0));
  endtask

  task automatic do_new_game();
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd0;
    @(negedge CLK25);
    new_game = 1'b0; move_valid = 1'b0;
    model_reset();
    check_state("newgame");
    repeat (3) @(negedge CLK25);
    check_state("newgame_discard");
  endtask

  task automatic do_move(input int c, input bit ng_mid);
    bit legal;
    int k = 0;
    while (move_ready !== 1'b1 && k < 40) begin @(negedge CLK25); k++; end
    if (move_ready !== 1'b1) begin check_eq("ready_timeout", 32'(move_ready), 1); return; end
    move_valid = 1'b1; move_cell = 4'(c);
    @(negedge CLK25);
    move_valid = 1'b0;
    check_eq("ready_busy", 32'(move_ready), 0);
    if (ng_mid) begin
      @(negedge CLK25); @(negedge CLK25);
      new_game = 1'b1;
      @(negedge CLK25);
      new_game = 1'b0;
      model_reset();
      check_state("ng_mid");
      return;
    end
    model_move(c, legal);
    @(negedge CLK25);
    check_eq("err_pulse", 32'(move_err), 32'(!legal));
    if (legal) check_eq("ready_low_n1", 32'(move_ready), 0);
    repeat (9) @(negedge CLK25);
    check_state("after_move");
    check_eq("err_idle", 32'(move_err), 0);
  endtask

  initial begin
    int seq_win [5] = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int c, moves, cl, a;
    RST_BTN = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
    vsync = 1'b1; video_on = 1'b0; x = 10'd0; y = 9'd0;
    model_reset();
    for (int i = 0; i < 9; i++) begin disp[i] = 0; disp_win[i] = 0; end
    repeat (3) @(negedge CLK25);
    check_state("reset");
    check_eq("reset_err", 32'(move_err), 0);
    check_eq("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
    RST_BTN = 1'b1;
    @(negedge CLK25);

    // Empty-board render.
    check_pix("grid_241_10", 241, 10, 1'b1);
    check_pix("black_300_300", 300, 300, 1'b1);
    check_pix("von0", 241, 10, 1'b0);

    // X wins on row 0.
    foreach (seq_win[i]) do_move(seq_win[i], 1'b0);
    repeat (5) @(negedge CLK25);
    check_eq("win_ready_stays0", 32'(move_ready), 0);
    do_vsync();
    check_pix("xstroke_100_20", 100, 20, 1'b1);
    check_pix("hilite_90_5", 90, 5, 1'b1);

    // Illegal moves leave turn and board alone.
    do_new_game();
    do_vsync();
    check_pix("blank_after_ng", 100, 20, 1'b1);
    do_move(4, 1'b0);
    do_move(4, 1'b0);
    do_move(9, 1'b0);
    do_vsync();
    check_pix("cell4_still_x", 300, 220, 1'b1);

    // Draw.
    do_new_game();
    foreach (seq_draw[i]) do_move(seq_draw[i], 1'b0);
    do_vsync();
    check_pix("draw_o_cell1", 262, 80, 1'b1);

    // Restart in the middle of CHECK; display holds until vsync.
    do_new_game();
    do_move(0, 1'b0);
    do_vsync();
    do_move(4, 1'b1);
    check_pix("disp_hold", 100, 20, 1'b1);
    do_vsync();
    check_pix("disp_blank", 100, 20, 1'b1);

    // Random games.
    for (int g = 0; g < 6; g++) begin
      do_new_game();
      do_vsync();
      moves = 0;
      while (m_status == 0 && moves < 40) begin
        if ($urandom_range(0, 9) == 9) c = $urandom_range(9, 15);
        else c = $urandom_range(0, 8);
        do_move(c, 1'b0);
        moves++;
      end
      do_vsync();
      for (int p = 0; p < 9; p++) begin
        cl = p; a = $urandom_range(18, 141);
        check_pix("rnd_diag", 80 + (cl % 3) * 160 + a, (cl / 3) * 160 + a + $urandom_range(0, 3), 1'b1);
        check_pix("rnd_oedge", 80 + (cl % 3) * 160 + $urandom_range(19, 27), (cl / 3) * 160 + a, 1'b1);
      end
      for (int p = 0; p < 20; p++)
        check_pix("rnd_pix", $urandom_range(0, 639), $urandom_range(0, 479), ($urandom_range(0, 7) != 0));
    end

    @(negedge CLK25);
    check_eq("err_count", 32'(n_err_seen), 32'(n_err_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tictactoe_board_ctrl.md
# tictactoe_board_ctrl

Game-state controller for the TicTacToe VGA display. Accepts player moves over a valid/ready handshake, holds the 3x3 board, and alternates turns. After each move it runs a sequential win/draw check. It also renders the board by mapping the sync generator's pixel coordinates to 8-bit RGB. It sits between the input logic and the VGA outputs, in the 25 MHz pixel-clock domain alongside the 640x480 sync generator.

## Interface
- BOARD_X0, 80, left pixel column of the 480x480 board area
- CELL, 160, cell edge in pixels
- LINE_W, 4, grid line thickness in pixels
- CLK25  in  1  pixel clock, 25 MHz
- RST_BTN  in  1  asynchronous reset, active-low
- new_game  in  1  single-cycle pulse; restarts the game
- move_valid  in  1  move request
- move_cell  in  4  cell index 0..8, row-major, top-left = 0
- move_ready  out  1  move can be accepted
- move_err  out  1  single-cycle pulse when an accepted move is illegal
- turn  out  1  0 = X to move, 1 = O to move
- status  out  2  00 PLAY, 01 XWIN, 10 OWIN, 11 DRAW
- vsync  in  1  active-low vertical sync from the sync generator
- video_on  in  1  visible-area flag
- x  in  10  pixel column
- y  in  9  pixel row
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour, registered

## Operation
- Storage:
  - pend_board holds 9 x 2 bits (00 empty, 01 X, 10 O).
  - disp_board is a copy of pend_board used for rendering.
  - disp_board loads from pend_board on the vsync falling edge. This gives tear-free updates.
- State machine:
  - IDLE: move_ready = (status == PLAY). A handshake is move_valid & move_ready.
  - IDLE to APPLY on a handshake; move_cell is latched.
  - APPLY, illegal move (cell > 8 or cell occupied): pulse move_err, return to IDLE. turn and board are unchanged.
  - APPLY, legal move: write the mark for the current turn, go to CHECK with line index 0.
  - CHECK: test one of the 8 lines per cycle against the mark just placed.
    - Line order: rows 0-2, columns 0-2, main diagonal, anti-diagonal.
    - On a hit: status = XWIN/OWIN, win_mask = that line's cells, go to IDLE.
  - CHECK to FINAL after line 7 with no hit.
  - FINAL: if all 9 cells are non-empty, status = DRAW. Otherwise toggle turn. Go to IDLE.
- move_ready deasserts in every state except IDLE. It stays low in IDLE while status != PLAY.
- new_game has priority in every state, including mid-CHECK. On the next edge:
  - pend_board is cleared, status = PLAY, turn = X, win_mask = 0, state = IDLE.
  - A handshake in the same cycle is discarded.
  - disp_board clears at the next vsync falling edge.
- Render, from disp_board:
  - Board area: BOARD_X0 <= x < BOARD_X0 + 3*CELL and y < 3*CELL. Cell column and row are decoded by comparison; no divider.
  - lx, ly are 8-bit offsets within the cell.
  - Grid: white FF/FF/FF where an offset from an inner boundary (CELL, 2*CELL) is < LINE_W.
  - X mark: red FF/00/00 where 20 <= lx,ly < 140 and (|lx - ly| < 4 or |lx + ly - 159| < 4).
  - O mark: blue 00/00/FF as a square outline inset 20..139, 6 pixels thick.
  - Everything else is black.
  - video_on = 0 forces 00/00/00.

## Timing
- Reset values:
  - Outputs: move_ready 1, move_err 0, turn 0, status 00, VGA_R/G/B 00.
  - Internal: both boards empty, state IDLE.
- A handshake at edge N is followed by:
  - move_err at N+1 for an illegal move.
  - For a legal move: board write at N+1, status/turn update by N+10 at the latest.
  - move_ready is low from N+1 until the return to IDLE.
- RGB lags x/y/video_on by exactly 1 cycle. The top level delays hsync/vsync by 1 cycle to match.
- Display copy:
  - Takes effect on the cycle after the vsync falling edge is detected.
  - The edge detector holds a registered previous value, cleared to 1 on reset.
- If a vsync edge coincides with a write, the pre-write board is copied. The write shows at the following frame.

## Configuration
- WIN_HILITE_EN defined:
  - Cells in win_mask on disp_board render background 00/40/00 instead of black.
  - win_mask is captured into the display copy at the same vsync edge.
- WIN_HILITE_EN undefined:
  - win_mask logic is removed and there is no highlight.
  - status/turn behaviour is identical.

## Test plan
- Reset, then play X:0, O:3, X:1, O:4, X:2:
  - status = 01 within 10 cycles of the last accept.
  - move_ready stays 0 afterwards.
  - Pixel (x=100, y=20) in the following frame shows an X stroke, not black.
- X:4, then O:4:
  - move_err pulses 1 cycle after the second accept.
  - turn stays 1 and the board is unchanged.
  - move_cell = 9 also gives move_err.
- Play the draw sequence X:0 O:1 X:2 O:4 X:3 O:5 X:7 O:6 X:8 -> status = 11.
- Assert new_game two cycles into CHECK:
  - Next cycle: state IDLE, status 00, turn 0, move_ready 1.
  - Display goes blank only after the next vsync falling edge.
- Render checks, empty board, video_on = 1:
  - (x=241, y=10) gives FF/FF/FF on the next cycle.
  - (x=300, y=300) gives 00/00/00.
  - video_on = 0 gives 00/00/00 regardless of x/y.
- With WIN_HILITE_EN, after an X row-0 win, (x=90, y=5) renders 00/40/00. Without the macro it renders 00/00/00.
